pingpong_frame_buf: RTL
=======================

PINGPONG_FRAME_BUF -- requirements
Module: pingpong_frame_buf

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, word width of each pixel/data entry.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, address width; each bank holds 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter CNT_WIDTH, default 8, width of frame_cnt.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port wr_en  input  1  write request to current write bank.
REQ-007 SHALL have port wr_addr  input  ADDR_WIDTH  write address within write bank.
REQ-008 SHALL have port wr_data  input  DATA_WIDTH  write data.
REQ-009 SHALL have port wr_done  input  1  one-cycle pulse: writer has finished a frame.
REQ-010 SHALL have port wr_ready  output  1  write bank accepts writes.
REQ-011 SHALL have port rd_en  input  1  read request from current read bank.
REQ-012 SHALL have port rd_addr  input  ADDR_WIDTH  read address within read bank.
REQ-013 SHALL have port rd_done  input  1  one-cycle pulse: reader has finished a frame.
REQ-014 SHALL have port rd_data  output  DATA_WIDTH  registered read data.
REQ-015 SHALL have port rd_valid  output  1  read bank holds a complete published frame.
REQ-016 SHALL have port rd_bank  output  1  index of bank currently readable.
REQ-017 SHALL have port frame_cnt  output  CNT_WIDTH  count of bank swaps, wraps modulo 2**CNT_WIDTH.
REQ-018 SHALL have port wr_drop  output  1  sticky: a write was attempted while wr_ready=0.

Function
REQ-019 SHALL contain two banks; write bank is always !rd_bank.
REQ-020 SHALL implement FSM states INIT (no frame published), PUB (read bank valid, writer filling), WAIT (writer finished, waiting for reader).
REQ-021 INIT: wr_done -> swap, go PUB; rd_done ignored.
REQ-022 PUB: wr_done & rd_done same cycle -> swap, stay PUB; wr_done only -> WAIT; rd_done only -> stay PUB (frame repeats).
REQ-023 WAIT: rd_done -> swap, go PUB; wr_done ignored.
REQ-024 Swap SHALL toggle rd_bank and increment frame_cnt, both visible the cycle after the triggering edge.
REQ-025 wr_ready SHALL be 0 in WAIT, 1 otherwise (combinational from state).
REQ-026 Write with wr_en & wr_ready SHALL store wr_data at wr_addr of write bank; write in same cycle as wr_done SHALL land in the outgoing write bank.
REQ-027 wr_en while wr_ready=0 SHALL not modify memory and SHALL set wr_drop.
REQ-028 rd_valid SHALL be 0 in INIT, 1 in PUB and WAIT.
REQ-029 rd_en & rd_valid SHALL update rd_data one cycle later (latency 1); read in swap cycle SHALL return data from the pre-swap read bank.
REQ-030 rd_en while rd_valid=0, or rd_en=0, SHALL leave rd_data unchanged.
REQ-031 Reads and writes never target the same bank, so no read-during-write hazard exists.

Reset
REQ-032 reset SHALL force state INIT, rd_bank 0, frame_cnt 0, rd_data 0, wr_drop 0 at the next edge; reset overrides all other inputs in the same cycle.
REQ-033 Memory contents SHALL not be cleared by reset; reset mid-frame discards published status only.

Structure
REQ-034 Package pingpong_pkg SHALL hold the FSM state type (INIT, PUB, WAIT) and the bank count constant (2).
REQ-035 Each bank SHALL be one instance of sub-module pp_bank_mem (1 write port, 1 registered read port, parameterised DATA_WIDTH/ADDR_WIDTH).

Verification
REQ-036 Reset, then rd_en=1 rd_addr=0 -> rd_valid=0, rd_data stays 0, rd_bank=0, frame_cnt=0.
REQ-037 Write 0x0001..0x0008 to addr 0..7, pulse wr_done -> rd_valid=1, rd_bank=1, frame_cnt=1; read addr 0..7 returns 0x0001..0x0008, one cycle after each rd_en.
REQ-038 In PUB, pulse wr_done alone -> wr_ready=0; write 0xDEAD to addr 2 -> wr_drop=1, memory unchanged; pulse rd_done -> swap, frame_cnt=2, wr_ready=1.
REQ-039 In PUB, pulse wr_done and rd_done in same cycle with rd_en on addr 3 -> rd_data returns old-bank word, then rd_bank toggles, state stays PUB.
REQ-040 Drive 256 swaps with CNT_WIDTH=8 -> frame_cnt wraps 0xFF to 0x00; assert reset mid-frame in WAIT -> INIT, wr_ready=1, rd_valid=0, wr_drop=0.

Source files
------------

// File: rtl/pingpong_pkg.sv
// pingpong_pkg: shared FSM state type and bank count for the ping-pong frame buffer
package pingpong_pkg;
    typedef enum logic [1:0] {INIT, PUB, WAIT} state_t;
    localparam int NUM_BANKS = 2;
endpackage

// File: rtl/pp_bank_mem.sv
// pp_bank_mem: one frame bank, single write port and registered read port
module pp_bank_mem #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_rdata;
    always_ff @(posedge clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;
    always_ff @(posedge clk)
        if (rst) r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_raddr];
    assign o_rdata = r_rdata;
endmodule

// File: rtl/pingpong_frame_buf.sv
// pingpong_frame_buf: two-bank frame buffer handing frames from a writer to a reader
module pingpong_frame_buf
    import pingpong_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_done,
    output logic                  wr_ready,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_done,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_bank,
    output logic [CNT_WIDTH-1:0]  frame_cnt,
    output logic                  wr_drop
);
    state_t                r_state, w_next;
    logic                  r_rd_bank, r_rd_sel, r_wr_drop, w_swap, w_rd_fire;
    logic [CNT_WIDTH-1:0]  r_frame_cnt;
    logic [DATA_WIDTH-1:0] w_bank_rdata [NUM_BANKS];

    always_comb begin
        w_swap = (r_state == INIT && wr_done) || (r_state == PUB && wr_done && rd_done) ||
                 (r_state == WAIT && rd_done);
        w_next = (r_state == PUB && wr_done && !rd_done) ? WAIT : (w_swap ? PUB : r_state);
    end

    assign wr_ready  = r_state != WAIT;
    assign rd_valid  = r_state != INIT;
    assign w_rd_fire = rd_en && rd_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= INIT;
            r_rd_bank   <= 1'b0;
            r_rd_sel    <= 1'b0;
            r_frame_cnt <= '0;
            r_wr_drop   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_swap) r_rd_bank <= ~r_rd_bank;
            if (w_swap) r_frame_cnt <= r_frame_cnt + CNT_WIDTH'(1);
            if (wr_en && !wr_ready) r_wr_drop <= 1'b1;
            // output mux follows the bank that was actually read, not the post-swap one
            if (w_rd_fire) r_rd_sel <= r_rd_bank;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        pp_bank_mem #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mem (
            .clk     (clk),
            .rst     (reset),
            .i_we    (wr_en && wr_ready && !reset && (r_rd_bank != 1'(b))),
            .i_waddr (wr_addr),
            .i_wdata (wr_data),
            .i_re    (w_rd_fire && (r_rd_bank == 1'(b))),
            .i_raddr (rd_addr),
            .o_rdata (w_bank_rdata[b])
        );
    end

    assign rd_data   = w_bank_rdata[r_rd_sel];
    assign rd_bank   = r_rd_bank;
    assign frame_cnt = r_frame_cnt;
    assign wr_drop   = r_wr_drop;
endmodule
